// File: rtl/dm_responder_if.sv
// Request/response bus between the core's data-memory port and its responder.
// The master is the CPU side; the slave is the memory responder.
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: word array answering one load/store at a time
// after LATENCY wait states, with misalignment/out-of-range error reporting.
//
//   state | meaning
//   IDLE  | ready for a request; req_ready high
//   WAIT  | counting down wait states for the accepted request
//   RESP  | response held on the bus until resp_ready
module dm_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    dm_responder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            we_q, err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     rdata_q, rdata_nxt;
    logic            rerr_q, rerr_nxt;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            addr_err;
    logic [AW-1:0]   idx_in;

    assign idx_in   = bus.req_addr[AW+1:2];
    // Full upper-bit compare so out-of-range indices never alias into the array.
    assign addr_err = (bus.req_addr[1:0] != 2'b00) | (bus.req_addr[31:2] >= 30'(DEPTH));
    assign accept   = bus.req_valid & bus.req_ready;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = rerr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rdata_q <= rdata_nxt;
            rerr_q  <= rerr_nxt;
            if (accept) begin
                we_q  <= bus.req_we;
                err_q <= addr_err;
                idx_q <= idx_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdata_nxt = rdata_q;
        rerr_nxt  = rerr_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    rdata_nxt = (!we_q && !err_q) ? mem[idx_q] : 32'd0;
                    rerr_nxt  = err_q;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                    rdata_nxt = 32'd0;
                    rerr_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stores commit on the acceptance edge, so a later reset cannot undo them.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !addr_err)
            mem[idx_in] <= bus.req_wdata;
    end
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: expected responses are queued at request
// time and compared when the responder presents them.
module tb_dm_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   cyc;
    exp_t sb[$];

    dm_responder_if bus ();

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(bus.req_ready === 1'b1), 32'd1);
    endtask

    // One transaction: drive, accept, measure latency, optionally stall, handshake.
    task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
        exp_t e;
        int   lat;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        wait_ready(tag);
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat = 0;
        while (bus.resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (bus.resp_valid !== 1'b1) return;
        check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
        check({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, e.rdata);
            check({tag, "_hold_err"}, 32'(bus.resp_err), 32'(e.err));
            check({tag, "_hold_req_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_post_rdata"}, bus.resp_rdata, 32'd0);
        check({tag, "_post_err"}, 32'(bus.resp_err), 32'd0);
        check({tag, "_post_req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        int          acc_cyc [3];
        int          n_acc;
        int          n_rsp;
        exp_t        e;

        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_resp_rdata", bus.resp_rdata, 32'd0);
        check("reset_resp_err", 32'(bus.resp_err), 32'd0);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic store then load
        do_txn("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 0);
        do_txn("ld_10", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 0);

        // Load with response back-pressure
        do_txn("ld_10_stall", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 5);

        // Misaligned store must not modify word 4
        do_txn("st_13_misal", 1'b1, 32'h13, 32'h1234, 32'd0, 1'b1, 0);
        do_txn("ld_10_after", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 0);
        do_txn("ld_12_misal", 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, 0);

        // Out-of-range accesses never alias onto low words
        do_txn("st_0", 1'b1, 32'h0, 32'h0BADF00D, 32'd0, 1'b0, 0);
        do_txn("ld_400", 1'b0, 32'h400, 32'd0, 32'd0, 1'b1, 0);
        do_txn("st_400", 1'b1, 32'h400, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
        do_txn("ld_hi", 1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1, 0);
        do_txn("ld_0", 1'b0, 32'h0, 32'd0, 32'h0BADF00D, 1'b0, 0);
        do_txn("ld_10_noalias", 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 0);

        // Last legal word
        do_txn("st_3fc", 1'b1, 32'h3FC, 32'h13579BDF, 32'd0, 1'b0, 0);
        do_txn("ld_3fc", 1'b0, 32'h3FC, 32'd0, 32'h13579BDF, 1'b0, 1);

        // Reset in WAIT: no response, but the store stays committed
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hA5A5A5A5;
        wait_ready("rst_st");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rst_st_in_wait", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_abort_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_abort_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (LAT + 2) begin
            @(posedge clk); #1;
            check("rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        do_txn("ld_20", 1'b0, 32'h20, 32'd0, 32'hA5A5A5A5, 1'b0, 0);

        // Back-to-back loads with req_valid held and resp_ready held
        addrs[0] = 32'h10; datas[0] = 32'hDEADBEEF;
        addrs[1] = 32'h20; datas[1] = 32'hA5A5A5A5;
        addrs[2] = 32'h0;  datas[2] = 32'h0BADF00D;
        n_acc          = 0;
        n_rsp          = 0;
        bus.req_we     = 1'b0;
        bus.req_addr   = addrs[0];
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 60 && n_rsp < 3; i++) begin
            if (bus.resp_valid === 1'b1) begin
                check("b2b_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("b2b_rdata", bus.resp_rdata, e.rdata);
                    check("b2b_err", 32'(bus.resp_err), 32'(e.err));
                end
                n_rsp++;
            end
            if (bus.req_ready === 1'b1 && n_acc < 3) begin
                bus.req_addr = addrs[n_acc];
                acc_cyc[n_acc] = cyc + 1;
                sb.push_back('{rdata: datas[n_acc], err: 1'b0});
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 3) bus.req_valid = 1'b0;
        end
        bus.resp_ready = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_responses", 32'(n_rsp), 32'd3);
        // LATENCY wait cycles plus one RESP cycle lie between accepts.
        if (n_acc == 3) begin
            check("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LAT + 2));
            check("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(LAT + 2));
        end
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
